// File: rtl/pkt_sched_arbiter.sv
// Round-robin arbiter that turns one granted SRAM request into a head/body/tail
// flit packet for the outbound flit FIFO, honouring FIFO backpressure.
module pkt_sched_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    req_src,
    input  logic [8*NREQ-1:0]    req_dest,
    input  logic [16*NREQ-1:0]   req_data,
    input  logic                 fifo_full,
    output logic [NREQ-1:0]      grant,
    output logic [255:0]         flit_out,
    output logic                 write_enable,
    output logic                 busy,
    output logic [2:0]           cur_id,
    output logic [15:0]          pkt_count
);

    typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;

    state_t          state_q, state_d;
    logic [2:0]      last_q, last_d;
    logic [2:0]      cur_id_q, cur_id_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [255:0]    flit_q, flit_d;
    logic            we_q, we_d;
    logic [15:0]     pkt_count_q, pkt_count_d;
    logic [7:0]      src_q, src_d;
    logic [7:0]      dest_q, dest_d;
    logic [15:0]     data_q, data_d;

    logic [7:0]      req_pad;
    logic [3:0]      rr_sum;
    logic            win_found;
    logic [2:0]      win_idx;
    logic [7:0]      sel_src;
    logic [7:0]      sel_dest;
    logic [15:0]     sel_data;
    logic [NREQ-1:0] sel_grant;

    // Requests padded to 8 so a 3-bit rotating index is always in range.
    always_comb begin
        req_pad = '0;
        req_pad[NREQ-1:0] = req;
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        rr_sum    = 4'd0;
        for (int off = 1; off <= NREQ; off++) begin
            rr_sum = {1'b0, last_q} + 4'(off);
            if (rr_sum >= 4'(NREQ)) begin
                rr_sum = rr_sum - 4'(NREQ);
            end
            if (!win_found && req_pad[rr_sum[2:0]]) begin
                win_found = 1'b1;
                win_idx   = rr_sum[2:0];
            end
        end
    end

    always_comb begin
        sel_src   = '0;
        sel_dest  = '0;
        sel_data  = '0;
        sel_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == 3'(i)) begin
                sel_src      = req_src[8*i +: 8];
                sel_dest     = req_dest[8*i +: 8];
                sel_data     = req_data[16*i +: 16];
                sel_grant[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cur_id_d    = cur_id_q;
        grant_d     = '0;
        flit_d      = flit_q;
        we_d        = 1'b0;
        pkt_count_d = pkt_count_q;
        src_d       = src_q;
        dest_d      = dest_q;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    last_d   = win_idx;
                    cur_id_d = win_idx;
                    grant_d  = sel_grant;
                    src_d    = sel_src;
                    dest_d   = sel_dest;
                    data_d   = sel_data;
                    state_d  = HEAD;
                end
            end
            HEAD: begin
                if (!fifo_full) begin
                    flit_d  = {8'h00, src_q, dest_q, 224'b0};
                    we_d    = 1'b1;
                    state_d = BODY;
                end
            end
            BODY: begin
                if (!fifo_full) begin
                    flit_d  = {16{data_q}};
                    we_d    = 1'b1;
                    state_d = TAIL;
                end
            end
            TAIL: begin
                if (!fifo_full) begin
                    flit_d      = {240'b0, 16'hFFFF};
                    we_d        = 1'b1;
                    pkt_count_d = pkt_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 3'(NREQ - 1);
            cur_id_q    <= 3'd0;
            grant_q     <= '0;
            flit_q      <= '0;
            we_q        <= 1'b0;
            pkt_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cur_id_q    <= cur_id_d;
            grant_q     <= grant_d;
            flit_q      <= flit_d;
            we_q        <= we_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Operand latches need no reset: they are only read after a grant loads them.
    always_ff @(posedge clk) begin
        src_q  <= src_d;
        dest_q <= dest_d;
        data_q <= data_d;
    end

    assign grant        = grant_q;
    assign flit_out     = flit_q;
    assign write_enable = we_q;
    assign busy         = (state_q != IDLE);
    assign cur_id       = cur_id_q;
    assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_pkt_sched_arbiter.sv
// Bench for pkt_sched_arbiter: directed scenarios plus randomized traffic,
// all outputs compared each cycle against a packet-queue reference model.
module tb_pkt_sched_arbiter;

    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [8*NREQ-1:0]    req_src = '0;
    logic [8*NREQ-1:0]    req_dest = '0;
    logic [16*NREQ-1:0]   req_data = '0;
    logic                 fifo_full = 1'b0;
    logic [NREQ-1:0]      grant;
    logic [255:0]         flit_out;
    logic                 write_enable;
    logic                 busy;
    logic [2:0]           cur_id;
    logic [15:0]          pkt_count;

    pkt_sched_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .reset(reset), .req(req), .req_src(req_src), .req_dest(req_dest),
        .req_data(req_data), .fifo_full(fifo_full), .grant(grant), .flit_out(flit_out),
        .write_enable(write_enable), .busy(busy), .cur_id(cur_id), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic cmp_en = 1'b1;
    logic preload = 1'b0;
    logic [NREQ-1:0] sticky = '0;
    int glog[$];
    int gcyc[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a granted request becomes three queued flits; each
    // unstalled edge pops one flit; arbitration only when the queue is empty.
    logic [255:0]    m_q[$];
    logic [2:0]      m_last = 3'(NREQ - 1);
    logic [15:0]     m_count = '0;
    logic [NREQ-1:0] e_grant = '0;
    logic [255:0]    e_flit = '0;
    logic            e_we = 1'b0;
    logic            e_busy = 1'b0;
    logic [2:0]      e_cur = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_last  = 3'(NREQ - 1);
            m_count = '0;
            e_grant = '0;
            e_flit  = '0;
            e_we    = 1'b0;
            e_busy  = 1'b0;
            e_cur   = '0;
        end else begin
            e_grant = '0;
            e_we    = 1'b0;
            if (preload) m_count = 16'hFFFF;
            if (m_q.size() > 0) begin
                if (!fifo_full) begin
                    e_flit = m_q.pop_front();
                    e_we   = 1'b1;
                    if (m_q.size() == 0) m_count = m_count + 16'd1;
                end
            end else if (req != '0) begin
                int w;
                logic [7:0] s;
                logic [7:0] d;
                logic [15:0] dt;
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (int'(m_last) + k) % NREQ;
                    if (w < 0 && ((req >> c) & NREQ'(1)) != '0) w = c;
                end
                s  = 8'(req_src >> (8 * w));
                d  = 8'(req_dest >> (8 * w));
                dt = 16'(req_data >> (16 * w));
                m_q.push_back({8'h00, s, d, 224'b0});
                m_q.push_back({16{dt}});
                m_q.push_back({240'b0, 16'hFFFF});
                e_grant = NREQ'(1) << w;
                e_cur   = 3'(w);
                m_last  = 3'(w);
            end
            e_busy = (m_q.size() != 0);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("grant", 256'(grant), 256'(e_grant));
            check("flit_out", flit_out, e_flit);
            check("write_enable", 256'(write_enable), 256'(e_we));
            check("busy", 256'(busy), 256'(e_busy));
            check("cur_id", 256'(cur_id), 256'(e_cur));
            check("pkt_count", 256'(pkt_count), 256'(m_count));
        end
    end

    function automatic int idx_of(input logic [NREQ-1:0] g);
        for (int i = 0; i < NREQ; i++) begin
            if (((g >> i) & NREQ'(1)) != '0) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (grant != '0) begin
            glog.push_back(idx_of(grant));
            gcyc.push_back(cyc);
        end
        req = req & ~(grant & ~sticky);
    endtask

    task automatic set_req(input int i, input logic [7:0] s, input logic [7:0] d, input logic [15:0] dt);
        req_src  = (req_src & ~((8*NREQ)'(8'hFF) << (8 * i))) | ((8*NREQ)'(s) << (8 * i));
        req_dest = (req_dest & ~((8*NREQ)'(8'hFF) << (8 * i))) | ((8*NREQ)'(d) << (8 * i));
        req_data = (req_data & ~((16*NREQ)'(16'hFFFF) << (16 * i))) | ((16*NREQ)'(dt) << (16 * i));
        req      = req | (NREQ'(1) << i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0;
        sticky = '0;
        fifo_full = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        glog.delete();
        gcyc.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || req != '0) && n < 60) begin
            tick();
            n++;
        end
        check("idle_reached", 256'(busy), 256'(0));
    endtask

    task automatic collect(input int n);
        int t;
        t = 0;
        while (glog.size() < n && t < 80) begin
            tick();
            t++;
        end
        check("grant_count", 256'(glog.size()), 256'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        repeat (2) @(negedge clk);
        check("rst_flit", flit_out, 256'(0));
        check("rst_we", 256'(write_enable), 256'(0));
        check("rst_grant", 256'(grant), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_cnt", 256'(pkt_count), 256'(0));
        reset = 1'b0;

        // Single request.
        set_req(0, 8'h12, 8'h34, 16'hABCD);
        tick();
        check("t1_grant", 256'(grant), 256'(4'b0001));
        check("t1_busy", 256'(busy), 256'(1));
        tick();
        check("t1_head_we", 256'(write_enable), 256'(1));
        check("t1_head", flit_out, {8'h00, 8'h12, 8'h34, 224'b0});
        tick();
        check("t1_body", flit_out, {16{16'hABCD}});
        tick();
        check("t1_tail", flit_out, {240'b0, 16'hFFFF});
        check("t1_cnt", 256'(pkt_count), 256'(1));
        tick();
        check("t1_busy_fall", 256'(busy), 256'(0));
        check("t1_we_low", 256'(write_enable), 256'(0));

        // Four simultaneous requesters.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h10 + i), 8'(8'h20 + i), 16'(16'h1000 + i));
        collect(4);
        for (int i = 0; i < 4 && i < glog.size(); i++) check("t2_order", 256'(glog[i]), 256'(i));
        for (int i = 0; i + 1 < 4 && i + 1 < gcyc.size(); i++)
            check("t2_spacing", 256'(gcyc[i+1] - gcyc[i]), 256'(4));
        wait_idle();
        check("t2_cnt", 256'(pkt_count), 256'(4));

        // Two requesters holding continuously.
        do_reset();
        sticky = 4'b0101;
        set_req(0, 8'hA0, 8'hB0, 16'h0A0A);
        set_req(2, 8'hA2, 8'hB2, 16'h2A2A);
        collect(4);
        for (int i = 0; i < 4 && i < glog.size(); i++) check("t3_order", 256'(glog[i]), 256'((i % 2) * 2));
        sticky = '0;
        req = '0;
        wait_idle();

        // Three stalled cycles in BODY.
        do_reset();
        set_req(0, 8'h55, 8'h66, 16'hBEEF);
        tick();
        start = cyc;
        tick();
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_stall_we", 256'(write_enable), 256'(0));
            check("t4_stall_hold", flit_out, {8'h00, 8'h55, 8'h66, 224'b0});
        end
        fifo_full = 1'b0;
        tick();
        check("t4_body", flit_out, {16{16'hBEEF}});
        tick();
        check("t4_tail", flit_out, {240'b0, 16'hFFFF});
        check("t4_length", 256'(cyc - start + 1), 256'(7));
        tick();

        // Reset during a TAIL stall.
        do_reset();
        set_req(0, 8'hAA, 8'hBB, 16'h1111);
        tick();
        tick();
        tick();
        fifo_full = 1'b1;
        tick();
        check("t5_tail_stall", 256'(write_enable), 256'(0));
        #2 reset = 1'b1;
        #1;
        check("t5_rst_flit", flit_out, 256'(0));
        check("t5_rst_busy", 256'(busy), 256'(0));
        check("t5_rst_cnt", 256'(pkt_count), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        fifo_full = 1'b0;
        req = '0;
        set_req(1, 8'h56, 8'h78, 16'h2222);
        tick();
        check("t5_grant", 256'(grant), 256'(4'b0010));
        check("t5_cur", 256'(cur_id), 256'(1));
        tick();
        check("t5_head", flit_out, {8'h00, 8'h56, 8'h78, 224'b0});
        wait_idle();

        // Packet counter wrap.
        do_reset();
        cmp_en = 1'b0;
        force dut.pkt_count_q = 16'hFFFF;
        preload = 1'b1;
        tick();
        release dut.pkt_count_q;
        preload = 1'b0;
        cmp_en = 1'b1;
        check("t6_preload", 256'(pkt_count), 256'(16'hFFFF));
        set_req(2, 8'h01, 8'h02, 16'h0303);
        repeat (4) tick();
        check("t6_wrap", 256'(pkt_count), 256'(0));
        wait_idle();

        // Randomized traffic with backpressure and occasional async reset.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            tick();
            fifo_full = ($urandom_range(0, 99) < 30);
            for (int i = 0; i < NREQ; i++) begin
                if (((req >> i) & NREQ'(1)) == '0) begin
                    if ($urandom_range(0, 99) < 25)
                        set_req(i, 8'($urandom), 8'($urandom), 16'($urandom));
                    else begin
                        set_req(i, 8'($urandom), 8'($urandom), 16'($urandom));
                        req = req & ~(NREQ'(1) << i);
                    end
                end
            end
            if ($urandom_range(0, 999) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        req = '0;
        fifo_full = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
